ascon_bdi_packer: RTL and testbench
===================================

Name: ascon_bdi_packer

Overview:
Host-side transmitter for the Ascon core's block-data-input interface. It takes a byte stream tagged with segment type and end markers, packs it into CCW-bit words, and drives bdi, bdi_valid, bdi_type, bdi_eot and bdi_eoi toward the core. The last word of a segment carries a partial byte mask. A one-word output holding register decouples the byte side from core back-pressure.

Parameters:
CCW, 32, core data width in bits; legal values 32 and 64.
CCWD8, CCW/8, bytes per word and width of bdi_valid; derived, not overridable.

Ports:
clk  in  1  clock
rst  in  1  reset
in_data  in  8  input byte
in_valid  in  1  byte/marker valid
in_ready  out  1  byte accepted when in_valid & in_ready
in_type  in  4  segment type (D_NONCE, D_AD, D_MSG, D_TAG encodings)
in_last  in  1  this beat ends the segment
in_final  in  1  this beat ends the whole input; only meaningful with in_last
in_empty  in  1  beat carries no data byte, only markers; requires in_last
bdi  out  CCW  packed word; byte i on bdi[8i+:8]
bdi_valid  out  CCWD8  contiguous byte mask from bit 0 (e.g. 4'b0111)
bdi_ready  in  1  core accepts the word when bdi_valid!=0 & bdi_ready
bdi_type  out  4  type of the word
bdi_eot  out  1  last word of the segment
bdi_eoi  out  1  last word of the input
empty_eoi  out  1  one-cycle pulse: an empty final marker was dropped
busy  out  1  assembly or holding register non-empty

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: bdi=0, bdi_valid=0, bdi_type=0, bdi_eot=0, bdi_eoi=0, empty_eoi=0, busy=0, in_ready=0 while rst is high. Byte count, assembly register and holding register are all cleared.
- Assembly register:
  - Holds up to CCWD8 bytes, a byte count cnt, and the type latched from the first byte of the word.
  - An accepted data byte is written at lane cnt, and cnt increments.
  - Bytes within a word always share a type, because segments end with in_last.
- Word completion (assembly becomes complete) occurs on either event:
  - cnt reaches CCWD8 after the accept; eot/eoi are taken from that beat's in_last/in_final.
  - A data beat is accepted with in_last; eot=1 and eoi=in_final.
- Empty marker (in_empty & in_last accepted):
  - If cnt>0: completes the pending word with eot=1 and eoi=in_final; the mask is unchanged.
  - If cnt==0: nothing is emitted. If in_final=1, empty_eoi pulses the next cycle.
- Holding register is the bdi output. It is either EMPTY (bdi_valid=0) or FULL (bdi_valid = mask of cnt bytes).
  - On completion it loads next cycle if EMPTY, or if FULL and drained this cycle.
  - Latency: a word appears on bdi the cycle after its completing byte is accepted.
  - bdi, mask, type, eot and eoi stay stable while FULL and not accepted.
  - Unused byte lanes of bdi are 0.
- in_ready = !(assembly complete-pending & holding FULL & !(bdi_ready)).
  - Full throughput: one byte per cycle with bdi_ready held high.
  - A complete word in assembly stalls input until it is moved.
- FSM per side:
  - Assembly: FILL → PENDING when a word is complete but the holding register is blocked. PENDING → FILL when moved.
  - Holding: EMPTY → FULL on load. FULL → EMPTY on accept with no simultaneous load. FULL → FULL on simultaneous accept and load.
- A segment length that is an exact multiple of CCWD8 ends with a full-mask word with eot=1. No extra empty word is sent; the core's padding handles it.
- Simultaneous events:
  - Accept and reload in the same cycle: no bubble.
  - empty_eoi and a bdi handshake may coincide.
- Reset mid-word: partial bytes are discarded with no output.
- busy = (cnt>0) | PENDING | FULL.

Test Plan:
1. CCW=32, bdi_ready=1. AD bytes 01..06 with in_last on 06, then MSG bytes 10..13 with last and final. Required output sequence:
   - bdi=0x04030201, mask 1111, type AD, eot=0.
   - bdi=0x00000605, mask 0011, eot=1.
   - bdi=0x13121110, mask 1111, type MSG, eot=1, eoi=1.
   - No extra words.
2. Back-pressure: hold bdi_ready=0 for 10 cycles during a 12-byte MSG stream. Required:
   - in_ready drops after 8 bytes are buffered.
   - The bdi word is stable.
   - On release, words are drained in order with no loss or duplication.
3. Empty marker: AD byte AA with in_last=0, then an empty beat with in_last and in_final. Required: bdi=0x000000AA, mask 0001, eot=1, eoi=1; empty_eoi stays 0.
4. Empty final with cnt==0: a single empty beat with last and final. Required: no bdi word and one empty_eoi pulse.
5. CCW=64: a 16-byte NONCE segment. Required: two full words 0x0706050403020100 and 0x0F0E0D0C0B0A0908; eot=1 on the second; throughput 1 byte per cycle.
6. Assert rst after 3 bytes are accepted. Required:
   - All outputs go to 0 the next cycle.
   - A subsequent 1-byte segment emits mask 0001 containing only the new byte.

Source files
------------

// File: rtl/ascon_bdi_packer.sv
`default_nettype none
// ============================================================================
// Module   : ascon_bdi_packer
// Brief    : Packs a tagged byte stream into CCW-bit BDI words with a one-word
//            holding register toward the Ascon core.
// Revision : 1.0
// ============================================================================
module ascon_bdi_packer #(
    parameter int CCW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_type,
    input  logic             in_last,
    input  logic             in_final,
    input  logic             in_empty,
    output logic [CCW-1:0]   bdi,
    output logic [CCW/8-1:0] bdi_valid,
    input  logic             bdi_ready,
    output logic [3:0]       bdi_type,
    output logic             bdi_eot,
    output logic             bdi_eoi,
    output logic             empty_eoi,
    output logic             busy
);

    localparam int CCWD8  = CCW / 8;
    localparam int c_CNTW = $clog2(CCWD8 + 1);

    typedef enum logic {S_FILL = 1'b0, S_PENDING = 1'b1} asm_state_t;
    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} hold_state_t;

    asm_state_t        r_asm_st;
    hold_state_t       r_hold_st;
    logic [c_CNTW-1:0] r_cnt;
    logic [CCW-1:0]    r_data;
    logic [3:0]        r_type;
    logic              r_eot;
    logic              r_eoi;
    logic [CCW-1:0]    r_bdi;
    logic [CCWD8-1:0]  r_mask;
    logic [3:0]        r_btype;
    logic              r_beot;
    logic              r_beoi;
    logic              r_empty_eoi;

    logic              w_drain;
    logic              w_move;
    logic              w_acc;
    logic              w_is_data;
    logic              w_mkr;
    logic [c_CNTW-1:0] w_base_cnt;
    logic [c_CNTW-1:0] w_new_cnt;
    logic [CCW-1:0]    w_new_data;
    logic [3:0]        w_type;
    logic              w_cmpl;
    logic              w_load_new;

    function automatic logic [CCWD8-1:0] f_mask(input logic [c_CNTW-1:0] n);
        logic [CCWD8-1:0] m;
        for (int i = 0; i < CCWD8; i++) begin
            m[i] = (c_CNTW'(i) < n);
        end
        return m;
    endfunction

    assign w_drain  = (r_hold_st == S_FULL) && bdi_ready;
    assign w_move   = (r_asm_st == S_PENDING) && w_drain;
    assign in_ready = !rst && !((r_asm_st == S_PENDING) && (r_hold_st == S_FULL) && !bdi_ready);
    assign w_acc    = in_valid && in_ready;
    assign w_is_data = w_acc && !in_empty;
    assign w_mkr    = w_acc && in_empty && in_last;

    // A pending word leaving this cycle frees the assembly for the incoming byte
    assign w_base_cnt = w_move ? '0 : r_cnt;
    assign w_new_cnt  = w_base_cnt + c_CNTW'(w_is_data);
    assign w_type     = (w_base_cnt == '0) ? in_type : r_type;

    always_comb begin
        w_new_data = w_move ? '0 : r_data;
        for (int i = 0; i < CCWD8; i++) begin
            if (w_is_data && (w_base_cnt == c_CNTW'(i))) begin
                w_new_data[8*i +: 8] = in_data;
            end
        end
    end

    assign w_cmpl = (w_is_data && ((w_new_cnt == c_CNTW'(CCWD8)) || in_last))
                  || (w_mkr && (w_base_cnt != '0));
    assign w_load_new = w_cmpl && !w_move && ((r_hold_st == S_EMPTY) || w_drain);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm_st    <= S_FILL;
            r_hold_st   <= S_EMPTY;
            r_cnt       <= '0;
            r_data      <= '0;
            r_type      <= '0;
            r_eot       <= 1'b0;
            r_eoi       <= 1'b0;
            r_bdi       <= '0;
            r_mask      <= '0;
            r_btype     <= '0;
            r_beot      <= 1'b0;
            r_beoi      <= 1'b0;
            r_empty_eoi <= 1'b0;
        end else begin
            r_empty_eoi <= w_mkr && in_final && (w_base_cnt == '0);

            if (w_move) begin
                r_hold_st <= S_FULL;
                r_bdi     <= r_data;
                r_mask    <= f_mask(r_cnt);
                r_btype   <= r_type;
                r_beot    <= r_eot;
                r_beoi    <= r_eoi;
            end else if (w_load_new) begin
                r_hold_st <= S_FULL;
                r_bdi     <= w_new_data;
                r_mask    <= f_mask(w_new_cnt);
                r_btype   <= w_type;
                r_beot    <= in_last;
                r_beoi    <= in_last && in_final;
            end else if (w_drain) begin
                r_hold_st <= S_EMPTY;
                r_bdi     <= '0;
                r_mask    <= '0;
                r_btype   <= '0;
                r_beot    <= 1'b0;
                r_beoi    <= 1'b0;
            end

            if (w_load_new) begin
                r_asm_st <= S_FILL;
                r_cnt    <= '0;
                r_data   <= '0;
            end else if (w_cmpl) begin
                // Holding register blocked: park the finished word until it drains
                r_asm_st <= S_PENDING;
                r_cnt    <= w_new_cnt;
                r_data   <= w_new_data;
                r_type   <= w_type;
                r_eot    <= in_last;
                r_eoi    <= in_last && in_final;
            end else begin
                r_asm_st <= w_move ? S_FILL : r_asm_st;
                r_cnt    <= w_new_cnt;
                r_data   <= w_new_data;
                if (w_is_data) begin
                    r_type <= w_type;
                end
            end
        end
    end

    assign bdi       = r_bdi;
    assign bdi_valid = r_mask;
    assign bdi_type  = r_btype;
    assign bdi_eot   = r_beot;
    assign bdi_eoi   = r_beoi;
    assign empty_eoi = r_empty_eoi;
    assign busy      = (r_cnt != '0) || (r_asm_st == S_PENDING) || (r_hold_st == S_FULL);

endmodule
`default_nettype wire

// File: tb/tb_ascon_bdi_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_bdi_packer
// Brief    : Scoreboard bench for ascon_bdi_packer at CCW=32 and CCW=64.
// Revision : 1.0
// ============================================================================
module tb_ascon_bdi_packer;

    localparam logic [3:0] D_NONCE = 4'h1;
    localparam logic [3:0] D_AD    = 4'h2;
    localparam logic [3:0] D_MSG   = 4'h4;
    localparam logic [3:0] D_TAG   = 4'h8;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  mask;
        logic [3:0]  typ;
        logic        eot;
        logic        eoi;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data   [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [3:0]  in_type   [2];
    logic        in_last   [2];
    logic        in_final  [2];
    logic        in_empty  [2];
    logic        bdi_ready [2];
    logic [3:0]  bdi_type  [2];
    logic        bdi_eot   [2];
    logic        bdi_eoi   [2];
    logic        empty_eoi [2];
    logic        busy      [2];
    logic [31:0] bdi0;
    logic [3:0]  bv0;
    logic [63:0] bdi1;
    logic [7:0]  bv1;

    int          checks   = 0;
    int          failures = 0;
    word_t       exp0[$];
    word_t       exp1[$];
    logic [7:0]  mb0[$];
    logic [7:0]  mb1[$];
    logic [3:0]  mtype   [2];
    int          eoi_exp [2];
    int          acc0    = 0;
    int          stalls  = 0;
    bit          done    [2];
    word_t       pw      [2];
    bit          pst     [2];
    logic [3:0]  types   [4] = '{D_NONCE, D_AD, D_MSG, D_TAG};

    always #5 clk = ~clk;

    ascon_bdi_packer #(.CCW(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .in_type(in_type[0]), .in_last(in_last[0]),
        .in_final(in_final[0]), .in_empty(in_empty[0]), .bdi(bdi0), .bdi_valid(bv0),
        .bdi_ready(bdi_ready[0]), .bdi_type(bdi_type[0]), .bdi_eot(bdi_eot[0]),
        .bdi_eoi(bdi_eoi[0]), .empty_eoi(empty_eoi[0]), .busy(busy[0])
    );

    ascon_bdi_packer #(.CCW(64)) u_dut64 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .in_type(in_type[1]), .in_last(in_last[1]),
        .in_final(in_final[1]), .in_empty(in_empty[1]), .bdi(bdi1), .bdi_valid(bv1),
        .bdi_ready(bdi_ready[1]), .bdi_type(bdi_type[1]), .bdi_eot(bdi_eot[1]),
        .bdi_eoi(bdi_eoi[1]), .empty_eoi(empty_eoi[1]), .busy(busy[1])
    );

    task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reference: collect segment bytes; a word is due when CCWD8 bytes are held or the segment ends
    task automatic model(input int u, input logic [7:0] d, input logic [3:0] t,
                         input bit last, input bit fin, input bit emp);
        word_t w;
        int    n;
        int    nb;
        nb = (u == 0) ? 4 : 8;
        if (!emp) begin
            if (u == 0) mb0.push_back(d);
            else        mb1.push_back(d);
        end
        n = (u == 0) ? mb0.size() : mb1.size();
        if (!emp && n == 1) mtype[u] = t;
        if (n > 0 && (n == nb || last)) begin
            w = '0;
            for (int i = 0; i < n; i++) begin
                w.data[8*i +: 8] = (u == 0) ? mb0[i] : mb1[i];
                w.mask[i] = 1'b1;
            end
            w.typ = mtype[u];
            w.eot = last;
            w.eoi = last && fin;
            if (u == 0) begin exp0.push_back(w); mb0.delete(); end
            else        begin exp1.push_back(w); mb1.delete(); end
        end else if (emp && last && fin && n == 0) begin
            eoi_exp[u]++;
        end
    endtask

    task automatic send(input int u, input logic [7:0] d, input logic [3:0] t,
                        input bit last, input bit fin, input bit emp);
        in_data[u]  = d;
        in_type[u]  = t;
        in_last[u]  = last;
        in_final[u] = fin;
        in_empty[u] = emp;
        in_valid[u] = 1'b1;
        for (int k = 0; ; k++) begin
            @(negedge clk);
            if (in_ready[u]) begin
                stalls += k;
                if (u == 0) acc0++;
                model(u, d, t, last, fin, emp);
                break;
            end
            if (k > 200) begin
                chk(1'b0, "in_ready_timeout", 0, 1);
                in_valid[u] = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int u);
        in_valid[u] = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every bdi handshake and checks holding stability
    always @(negedge clk) begin
        word_t g;
        word_t e;
        for (int u = 0; u < 2; u++) begin
            if (u == 0) begin g.data = 64'(bdi0); g.mask = 8'(bv0); end
            else        begin g.data = bdi1;      g.mask = bv1;     end
            g.typ = bdi_type[u];
            g.eot = bdi_eot[u];
            g.eoi = bdi_eoi[u];
            if (rst) begin
                pst[u] = 1'b0;
            end else begin
                if (pst[u]) chk(g == pw[u], "hold_stable", g, pw[u]);
                if (g.mask != 0 && bdi_ready[u]) begin
                    if ((u == 0 && exp0.size() == 0) || (u == 1 && exp1.size() == 0)) begin
                        chk(1'b0, "unexpected_word", g, 0);
                    end else begin
                        if (u == 0) e = exp0.pop_front();
                        else        e = exp1.pop_front();
                        chk(g == e, (u == 0) ? "word32" : "word64", g, e);
                    end
                end
                if (empty_eoi[u]) begin
                    chk(eoi_exp[u] > 0, "empty_eoi_pulse", 1, eoi_exp[u]);
                    if (eoi_exp[u] > 0) eoi_exp[u]--;
                end
                pst[u] = (g.mask != 0) && !bdi_ready[u];
                pw[u]  = g;
            end
        end
    end

    task automatic rand_drv(input int u);
        int         len;
        bit         fin;
        bit         emp_end;
        logic [3:0] t;
        for (int s = 0; s < 60; s++) begin
            len     = $urandom_range(0, 11);
            t       = types[$urandom_range(0, 3)];
            fin     = ($urandom_range(0, 7) == 0);
            emp_end = (len > 0) && ($urandom_range(0, 3) == 0);
            if (len == 0) begin
                send(u, 8'h00, t, 1'b1, fin, 1'b1);
            end else begin
                for (int i = 0; i < len; i++) begin
                    send(u, 8'($urandom), t, (i == len - 1) && !emp_end, fin, 1'b0);
                end
                if (emp_end) send(u, 8'h00, t, 1'b1, fin, 1'b1);
            end
            if ($urandom_range(0, 3) == 0) begin
                idle(u);
                settle($urandom_range(1, 3));
            end
        end
        idle(u);
        done[u] = 1'b1;
    endtask

    initial begin
        int a0;
        int s0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0; in_data[u] = '0; in_type[u] = '0; in_last[u] = 1'b0;
            in_final[u] = 1'b0; in_empty[u] = 1'b0; bdi_ready[u] = 1'b1;
            eoi_exp[u] = 0; mtype[u] = '0; done[u] = 1'b0; pst[u] = 1'b0; pw[u] = '0;
        end
        rst = 1'b1;
        settle(3);
        chk({bdi0, bv0, bdi_type[0], bdi_eot[0], bdi_eoi[0], empty_eoi[0], busy[0]} == '0,
            "reset_outputs32", {bdi0, bv0, bdi_type[0], bdi_eot[0], bdi_eoi[0], empty_eoi[0], busy[0]}, 0);
        chk({bdi1, bv1, bdi_type[1], bdi_eot[1], bdi_eoi[1], empty_eoi[1], busy[1]} == '0,
            "reset_outputs64", {bdi1, bv1, bdi_type[1], bdi_eot[1], bdi_eoi[1], empty_eoi[1], busy[1]}, 0);
        chk(!in_ready[0] && !in_ready[1], "reset_in_ready", {in_ready[0], in_ready[1]}, 0);
        rst = 1'b0;

        // AD then final MSG segment
        for (int i = 1; i <= 6; i++) send(0, 8'(i), D_AD, i == 6, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(0, 8'(8'h10 + i), D_MSG, i == 3, i == 3, 1'b0);
        idle(0);
        settle(6);
        chk(exp0.size() == 0, "t1_drained", exp0.size(), 0);

        // Back-pressure during a 12-byte stream
        bdi_ready[0] = 1'b0;
        a0 = acc0;
        fork
            for (int i = 0; i < 12; i++) send(0, 8'($urandom), D_MSG, i == 11, i == 11, 1'b0);
            begin
                settle(10);
                chk(acc0 - a0 == 8, "bp_bytes_buffered", acc0 - a0, 8);
                chk(in_ready[0] == 1'b0, "bp_in_ready_low", in_ready[0], 0);
                bdi_ready[0] = 1'b1;
            end
        join
        idle(0);
        settle(6);
        chk(exp0.size() == 0, "t2_drained", exp0.size(), 0);

        // Empty marker closing a partial word, then an empty final with nothing pending
        send(0, 8'hAA, D_AD, 1'b0, 1'b0, 1'b0);
        send(0, 8'h00, D_AD, 1'b1, 1'b1, 1'b1);
        idle(0);
        settle(4);
        chk(exp0.size() == 0, "t3_drained", exp0.size(), 0);
        send(0, 8'h00, D_TAG, 1'b1, 1'b1, 1'b1);
        idle(0);
        settle(4);
        chk(eoi_exp[0] == 0, "t4_empty_eoi_seen", eoi_exp[0], 0);

        // 64-bit NONCE at full rate
        s0 = stalls;
        for (int i = 0; i < 16; i++) send(1, 8'(i), D_NONCE, i == 15, 1'b0, 1'b0);
        chk(stalls == s0, "t5_throughput_stalls", stalls - s0, 0);
        idle(1);
        settle(4);
        chk(exp1.size() == 0, "t5_drained", exp1.size(), 0);

        // Reset in the middle of a word
        for (int i = 0; i < 3; i++) send(0, 8'(8'hC0 + i), D_MSG, 1'b0, 1'b0, 1'b0);
        idle(0);
        chk(busy[0] == 1'b1, "t6_busy_partial", busy[0], 1);
        rst = 1'b1;
        settle(1);
        chk({bdi0, bv0, bdi_type[0], bdi_eot[0], bdi_eoi[0], empty_eoi[0], busy[0], in_ready[0]} == '0,
            "t6_reset_outputs", {bdi0, bv0, bdi_type[0], bdi_eot[0], bdi_eoi[0], empty_eoi[0], busy[0], in_ready[0]}, 0);
        mb0.delete();
        rst = 1'b0;
        send(0, 8'h5A, D_MSG, 1'b1, 1'b1, 1'b0);
        idle(0);
        settle(4);
        chk(exp0.size() == 0, "t6_drained", exp0.size(), 0);

        // Randomized traffic with random core back-pressure on both widths
        fork
            rand_drv(0);
            rand_drv(1);
            while (!(done[0] && done[1])) begin
                @(posedge clk); #1;
                bdi_ready[0] = ($urandom_range(0, 3) != 0);
                bdi_ready[1] = ($urandom_range(0, 3) != 0);
            end
        join
        bdi_ready[0] = 1'b1;
        bdi_ready[1] = 1'b1;
        settle(20);
        chk(exp0.size() == 0 && exp1.size() == 0, "rand_drained", {exp0.size(), exp1.size()}, 0);
        chk(eoi_exp[0] == 0 && eoi_exp[1] == 0, "rand_empty_eoi", {eoi_exp[0], eoi_exp[1]}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
